lut_neuron_array: RTL and testbench

Runtime-loadable, pipelined array of `N_NEURONS` LUT neurons for LogicNets layers. Each neuron maps an `IN_BITS` input word to an `OUT_BITS` output through a distributed-RAM truth table. Tables are written over a configuration port instead of being fixed at synthesis. Sits between two layer stages on a valid/ready stream and adds a load/run control FSM, so one netlist serves retrained models.

---
 rtl/lut_neuron_pkg.sv | 17 +
 rtl/lut_neuron_array_ram.sv | 33 +++
 rtl/lut_neuron_array.sv | 126 ++++++++++++
 tb/tb_lut_neuron_array.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_neuron_pkg.sv
// lut_neuron_pkg
// Shared definitions for the runtime-loadable LUT neuron array:
//   lut_state_t : control FSM states (LOAD, RUN, DRAIN)
//   sel_w(n)    : width of a neuron-select field for n neurons, never below 1
package lut_neuron_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } lut_state_t;

  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lut_neuron_array_ram.sv
// lut_ram
// One neuron truth table: 2^ADDR_W x DATA_W distributed RAM with a
// synchronous write port and an asynchronous read port. No reset, so the
// contents survive a system reset.
// Ports:
//   clk   : write clock
//   we    : write strobe
//   waddr : write address
//   wdata : write data
//   raddr : combinational read address
//   rdata : combinational read data
module lut_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  (* ram_style = "distributed", rom_style = "distributed" *)
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_array.sv
// lut_neuron_array
// Pipelined array of N_NEURONS LUT neurons whose truth tables are loaded at
// runtime. A LOAD/RUN/DRAIN FSM gates table writes against streaming so a
// table is never read while it is being written.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake, in_data holds N_NEURONS addresses
//   out_valid/out_ready   : output handshake, out_data holds N_NEURONS results
//   cfg_we/sel/addr/data  : table write port (honoured only in LOAD)
//   cfg_commit            : LOAD -> RUN
//   cfg_unlock            : RUN -> DRAIN -> LOAD
//   cfg_err               : sticky illegal-configuration flag
//   running               : FSM is in RUN
module lut_neuron_array
  import lut_neuron_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int IN_BITS   = 8,
  parameter int OUT_BITS  = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_NEURONS*IN_BITS-1:0]    in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N_NEURONS*OUT_BITS-1:0]   out_data,
  input  logic                            cfg_we,
  input  logic [sel_w(N_NEURONS)-1:0]     cfg_sel,
  input  logic [IN_BITS-1:0]              cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_data,
  input  logic                            cfg_commit,
  input  logic                            cfg_unlock,
  output logic                            cfg_err,
  output logic                            running
);

  lut_state_t                    state;
  logic                          running_q;
  logic                          err_q;
  logic                          sel_bad;
  logic                          wr_ok;
  logic                          accept_p0;
  logic [N_NEURONS*OUT_BITS-1:0] rd_p0;
  logic                          vld_p1;
  logic [N_NEURONS*OUT_BITS-1:0] data_p1;

  // A select beyond the last neuron can only occur when N_NEURONS is not a
  // power of two; it is reported rather than silently aliased.
  assign sel_bad = (32'(cfg_sel) >= N_NEURONS);
  assign wr_ok   = cfg_we && (state == LOAD) && !sel_bad;

  // Unlock closes the input in the cycle it is seen, so nothing new enters
  // once the FSM has decided to drain.
  assign in_ready  = (state == RUN) && !cfg_unlock && (!vld_p1 || out_ready);
  assign accept_p0 = in_valid && in_ready;

  // Stage p0: combinational table lookup addressed straight from in_data
  for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
    logic we_k;
    assign we_k = wr_ok && (32'(cfg_sel) == k);

    lut_ram #(
      .ADDR_W (IN_BITS),
      .DATA_W (OUT_BITS)
    ) u_ram (
      .clk   (clk),
      .we    (we_k),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .raddr (in_data[k*IN_BITS +: IN_BITS]),
      .rdata (rd_p0[k*OUT_BITS +: OUT_BITS])
    );
  end

  // Stage p1: single output register, also the only buffer in the array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (accept_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= rd_p0;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      running_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (cfg_we && ((state != LOAD) || sel_bad)) err_q <= 1'b1;
      case (state)
        LOAD: begin
          if (cfg_commit) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (cfg_unlock) begin
            state     <= DRAIN;
            running_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (!vld_p1) state <= LOAD;
        end
        default: begin
          state     <= LOAD;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign cfg_err   = err_q;
  assign running   = running_q;

endmodule

// File: tb/tb_lut_neuron_array.sv
module tb_lut_neuron_array;

  localparam int N  = 4;
  localparam int IB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N*IB-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          cfg_we;
  logic [1:0]    cfg_sel;
  logic [IB-1:0] cfg_addr;
  logic [0:0]    cfg_data;
  logic          cfg_commit;
  logic          cfg_unlock;
  logic          cfg_err;
  logic          running;

  // second, non-power-of-two instance for the out-of-range select case
  logic          c3_in_ready, c3_out_valid, c3_err, c3_running;
  logic [2:0]    c3_out_data;
  logic          c3_we;
  logic [1:0]    c3_sel;

  logic ready_req = 1'b1;
  logic rnd_mode  = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [N-1:0] sb[$];
  logic         tbl [N][256];

  always #5 clk = ~clk;

  lut_neuron_array #(.N_NEURONS(N), .IN_BITS(IB), .OUT_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_unlock(cfg_unlock),
    .cfg_err(cfg_err), .running(running)
  );

  lut_neuron_array #(.N_NEURONS(3), .IN_BITS(IB), .OUT_BITS(1)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(1'b0), .in_ready(c3_in_ready), .in_data(24'h0),
    .out_valid(c3_out_valid), .out_ready(1'b1), .out_data(c3_out_data),
    .cfg_we(c3_we), .cfg_sel(c3_sel), .cfg_addr(8'h05), .cfg_data(1'b1),
    .cfg_commit(1'b0), .cfg_unlock(1'b0),
    .cfg_err(c3_err), .running(c3_running)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each neuron looks its own address byte up in its own table
  function automatic logic [N-1:0] model(input logic [N*IB-1:0] w);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = tbl[k][w[k*IB +: IB]];
    return r;
  endfunction

  // out_ready driver: either the requested level or random backpressure
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : ready_req;
    end
  end

  // Monitor: pop and compare on every output transfer
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(out_data), 32'hdead);
      end else begin
        chk("out_data", 32'(out_data), 32'(sb.pop_front()));
      end
    end
  end

  task automatic send(input logic [N*IB-1:0] w);
    int t = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (in_ready) sb.push_back(model(w));
    else chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input int sel, input int addr, input logic d);
    cfg_we   = 1'b1;
    cfg_sel  = 2'(sel);
    cfg_addr = 8'(addr);
    cfg_data = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(posedge clk);
    #1;
    cfg_commit = 1'b0;
  endtask

  task automatic wait_empty();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      t++;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] held;
    logic [N*IB-1:0] w;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0;
    cfg_commit = 1'b0; cfg_unlock = 1'b0; c3_we = 1'b0; c3_sel = '0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data), 0);
    chk("rst_in_ready",  32'(in_ready), 0);
    chk("rst_cfg_err",   32'(cfg_err), 0);
    chk("rst_running",   32'(running), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("load_in_ready", 32'(in_ready), 0);

    // Load: out = addr[6] ^ (k==1)
    for (int k = 0; k < N; k++)
      for (int a = 0; a < 256; a++) begin
        tbl[k][a] = a[6] ^ (k == 1);
        cfg_write(k, a, tbl[k][a]);
      end
    chk("no_err_after_load", 32'(cfg_err), 0);
    cfg_unlock = 1'b1;   // ignored in LOAD
    @(posedge clk); #1;
    cfg_unlock = 1'b0;
    commit();
    chk("running_after_commit", 32'(running), 1);
    commit();            // ignored in RUN
    chk("running_after_2nd_commit", 32'(running), 1);

    // Directed stream from the load-and-stream case
    send({N{8'h40}});
    chk("n0n1_0x40", 32'(out_data[1:0]), 32'b01);
    send({N{8'h00}});
    chk("n0n1_0x00", 32'(out_data[1:0]), 32'b10);
    send({N{8'h40}});
    send({N{8'hFF}});
    chk("n0n1_0xFF", 32'(out_data[1:0]), 32'b01);
    wait_empty();

    // Backpressure: one word accepted, then held for 5 cycles
    ready_req = 1'b0;
    w = $urandom();
    send(w);
    held = model(w);
    in_valid = 1'b1;
    in_data  = $urandom();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_data_held", 32'(out_data), 32'(held));
    end
    @(posedge clk); #1;
    ready_req = 1'b1;
    send(in_data);
    rnd_mode = 1'b1;
    for (int i = 0; i < 256; i++) send($urandom());
    rnd_mode = 1'b0;
    wait_empty();

    // Unlock with a word pending, then a write in DRAIN
    ready_req = 1'b0;
    send($urandom());
    cfg_unlock = 1'b1;
    @(posedge clk); #1;
    cfg_unlock = 1'b0;
    chk("drain_running", 32'(running), 0);
    chk("drain_in_ready", 32'(in_ready), 0);
    cfg_write(3, 8'h40, ~tbl[3][8'h40]);
    chk("drain_write_err", 32'(cfg_err), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drain_word_held", 32'(out_valid), 1);
    @(posedge clk); #1;
    ready_req = 1'b1;
    @(posedge clk);      // pending word taken
    @(posedge clk); #1;  // LOAD reached
    for (int a = 0; a < 256; a++) begin
      tbl[2][a] = a[0];
      cfg_write(2, a, tbl[2][a]);
    end
    commit();
    chk("resume_running", 32'(running), 1);
    send({N{8'h40}});    // neuron3 must still see its original entry
    for (int i = 0; i < 20; i++) send($urandom());
    wait_empty();

    // Reset mid-stream
    ready_req = 1'b0;
    send($urandom());
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_out_data",  32'(out_data), 0);
    chk("mrst_in_ready",  32'(in_ready), 0);
    chk("mrst_cfg_err",   32'(cfg_err), 0);
    chk("mrst_running",   32'(running), 0);
    sb.delete();
    ready_req = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    commit();
    for (int i = 0; i < 20; i++) send($urandom());
    wait_empty();

    // Illegal write in RUN
    cfg_write(0, 0, 1'b1);
    chk("run_write_err", 32'(cfg_err), 1);
    send({N{8'h00}});
    wait_empty();

    // Write and commit together
    cfg_unlock = 1'b1;
    @(posedge clk); #1;
    cfg_unlock = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tbl[0][8'h11] = 1'b1;
    cfg_commit = 1'b1;
    cfg_write(0, 8'h11, 1'b1);
    cfg_commit = 1'b0;
    chk("wc_running", 32'(running), 1);
    send({N{8'h11}});
    wait_empty();

    // Unlock drops in_ready in the same cycle
    in_valid   = 1'b1;
    in_data    = $urandom();
    cfg_unlock = 1'b1;
    #1;
    chk("unlock_same_cycle_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    cfg_unlock = 1'b0;
    in_valid   = 1'b0;
    repeat (3) @(posedge clk);

    // Out-of-range select on a 3-neuron array
    c3_we = 1'b1; c3_sel = 2'd2;
    @(posedge clk); #1;
    chk("n3_sel2_err", 32'(c3_err), 0);
    c3_sel = 2'd3;
    @(posedge clk); #1;
    c3_we = 1'b0;
    chk("n3_sel3_err", 32'(c3_err), 1);

    wait_empty();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
